// File: rtl/ca_pkg.sv
// Shared types and helpers for the cellular-automaton row engine.
package ca_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEED    = 3'd1,
        WRITE   = 3'd2,
        ROW_END = 3'd3,
        DONE    = 3'd4
    } ca_state_t;

    localparam logic [15:0] CA_FG_DEFAULT = 16'h0FFF;
    localparam logic [15:0] CA_BG_DEFAULT = 16'h0000;

    // Wolfram rule lookup: the neighbourhood {left, centre, right} indexes the rule byte.
    function automatic logic ca_next_cell(input logic [7:0] rule,
                                          input logic       l,
                                          input logic       c,
                                          input logic       r);
        return rule[{l, c, r}];
    endfunction

endpackage

// File: rtl/ca_row_shifter.sv
// Row storage for the automaton: the current row shifts out one cell per
// accepted pixel while the next generation is shifted in from the MSB side.
module ca_row_shifter
    import ca_pkg::*;
#(
    parameter int HSIZE = 320
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rule,
    input  logic       load_seed,
    input  logic       shift,
    input  logic       swap,
    output logic       cell_out
);

    localparam logic [HSIZE-1:0] SEED_ROW = {{(HSIZE-1){1'b0}}, 1'b1} << (HSIZE / 2);

    logic [HSIZE-1:0] cur_row_q, cur_row_d;
    logic [HSIZE-1:0] nxt_row_q, nxt_row_d;
    logic             left_q, left_d;
    logic             nbit_s;

    // Next-state selection: seed load, generation swap, or one-cell shift.
    always_comb begin
        cur_row_d = cur_row_q;
        nxt_row_d = nxt_row_q;
        left_d    = left_q;
        nbit_s    = ca_next_cell(rule, left_q, cur_row_q[0], cur_row_q[1]);
        if (load_seed) begin
            cur_row_d = SEED_ROW;
            nxt_row_d = '0;
            left_d    = 1'b0;
        end else if (swap) begin
            cur_row_d = nxt_row_q;
            left_d    = 1'b0;
        end else if (shift) begin
            // Zero fill keeps the right boundary dead; left_q starts at 0 for the left one.
            left_d    = cur_row_q[0];
            cur_row_d = cur_row_q >> 1;
            nxt_row_d = {nbit_s, nxt_row_q[HSIZE-1:1]};
        end else begin
            cur_row_d = cur_row_q;
        end
    end

    // Row registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_row_q <= '0;
            nxt_row_q <= '0;
            left_q    <= 1'b0;
        end else begin
            cur_row_q <= cur_row_d;
            nxt_row_q <= nxt_row_d;
            left_q    <= left_d;
        end
    end

    assign cell_out = cur_row_q[0];

endmodule

// File: rtl/ca_row_engine.sv
// Elementary cellular-automaton frame generator streaming pixels as
// Avalon-MM writes, row-major, one generation per frame line.
module ca_row_engine
    import ca_pkg::*;
#(
    parameter int                 HSIZE    = 320,
    parameter int                 VSIZE    = 240,
    parameter int                 AVN_AW   = 18,
    parameter int                 AVN_DW   = 16,
    parameter logic [AVN_DW-1:0]  FG_COLOR = AVN_DW'(CA_FG_DEFAULT),
    parameter logic [AVN_DW-1:0]  BG_COLOR = AVN_DW'(CA_BG_DEFAULT)
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [7:0]        ca_rule,
    input  logic              ca_start,
    output logic              ca_busy,
    output logic              ca_done,
    output logic              vram_avn_write,
    output logic [AVN_AW-1:0] vram_avn_address,
    output logic [AVN_DW-1:0] vram_avn_writedata,
    input  logic              vram_avn_waitrequest
);

    localparam int XW = $clog2(HSIZE);
    localparam int YW = (VSIZE > 1) ? $clog2(VSIZE) : 1;

    ca_state_t         state_q, state_d;
    logic [7:0]        rule_q, rule_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [AVN_AW-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic accept_s, last_x_s, last_y_s;
    logic load_seed_s, shift_s, swap_s, cell_s;

    assign accept_s = write_q & ~vram_avn_waitrequest;
    assign last_x_s = (x_q == XW'(HSIZE - 1));
    assign last_y_s = (y_q == YW'(VSIZE - 1));

    // FSM, counters and row-shifter controls; nothing moves while a write stalls.
    always_comb begin
        state_d     = state_q;
        rule_d      = rule_q;
        x_d         = x_q;
        y_d         = y_q;
        addr_d      = addr_q;
        load_seed_s = 1'b0;
        shift_s     = 1'b0;
        swap_s      = 1'b0;
        case (state_q)
            IDLE: begin
                if (ca_start) begin
                    rule_d  = ca_rule;
                    state_d = SEED;
                end else begin
                    state_d = IDLE;
                end
            end
            SEED: begin
                load_seed_s = 1'b1;
                x_d         = '0;
                y_d         = '0;
                addr_d      = '0;
                state_d     = WRITE;
            end
            WRITE: begin
                if (accept_s) begin
                    shift_s = 1'b1;
                    if (last_x_s && last_y_s) begin
                        // Final pixel: address stays on the last written word.
                        state_d = DONE;
                    end else if (last_x_s) begin
                        addr_d  = addr_q + AVN_AW'(1);
                        state_d = ROW_END;
                    end else begin
                        addr_d  = addr_q + AVN_AW'(1);
                        x_d     = x_q + XW'(1);
                    end
                end else begin
                    state_d = WRITE;
                end
            end
            ROW_END: begin
                swap_s  = 1'b1;
                x_d     = '0;
                y_d     = y_q + YW'(1);
                state_d = WRITE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        write_d = (state_d == WRITE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    // State, counters and registered handshake outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            rule_q  <= 8'h00;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rule_q  <= rule_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    ca_row_shifter #(
        .HSIZE (HSIZE)
    ) u_shifter (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .rule      (rule_q),
        .load_seed (load_seed_s),
        .shift     (shift_s),
        .swap      (swap_s),
        .cell_out  (cell_s)
    );

    assign vram_avn_write     = write_q;
    assign vram_avn_address   = addr_q;
    assign vram_avn_writedata = cell_s ? FG_COLOR : BG_COLOR;
    assign ca_busy            = busy_q;
    assign ca_done            = done_q;

endmodule

// File: tb/tb_ca_row_engine.sv
// Directed bench for ca_row_engine: small 8-wide frames with hand-computed
// rows, a full default-size frame, backpressure, busy disturbance and reset.
module tb_ca_row_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [7:0]  rule;
    logic        start;
    logic        wr;
    logic        sel;
    logic        b_start;

    logic        s_busy, s_done, s_write;
    logic [17:0] s_addr;
    logic [15:0] s_data;
    logic        t_busy, t_done, t_write;
    logic [17:0] t_addr;
    logic [15:0] t_data;
    logic        b_busy, b_done, b_write;
    logic [17:0] b_addr;
    logic [15:0] b_data;

    int total = 0;
    int bad   = 0;

    ca_row_engine #(.HSIZE(8), .VSIZE(4)) u_small (
        .sys_clk(clk), .sys_rst_n(rst_n), .ca_rule(rule), .ca_start(start & ~sel),
        .ca_busy(s_busy), .ca_done(s_done), .vram_avn_write(s_write),
        .vram_avn_address(s_addr), .vram_avn_writedata(s_data),
        .vram_avn_waitrequest(wr & ~sel));

    ca_row_engine #(.HSIZE(8), .VSIZE(3)) u_tri (
        .sys_clk(clk), .sys_rst_n(rst_n), .ca_rule(rule), .ca_start(start & sel),
        .ca_busy(t_busy), .ca_done(t_done), .vram_avn_write(t_write),
        .vram_avn_address(t_addr), .vram_avn_writedata(t_data),
        .vram_avn_waitrequest(wr & sel));

    ca_row_engine u_big (
        .sys_clk(clk), .sys_rst_n(rst_n), .ca_rule(8'h00), .ca_start(b_start),
        .ca_busy(b_busy), .ca_done(b_done), .vram_avn_write(b_write),
        .vram_avn_address(b_addr), .vram_avn_writedata(b_data),
        .vram_avn_waitrequest(1'b0));

    logic        m_busy, m_done, m_write;
    logic [17:0] m_addr;
    logic [15:0] m_data;
    assign m_busy  = sel ? t_busy  : s_busy;
    assign m_done  = sel ? t_done  : s_done;
    assign m_write = sel ? t_write : s_write;
    assign m_addr  = sel ? t_addr  : s_addr;
    assign m_data  = sel ? t_data  : s_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one 8-wide frame; rows[n] is the expected cell for write n (bit 8*y+x).
    task automatic frame(input logic [7:0] r, input logic [31:0] rows, input int nrows,
                         input bit stall, input bit disturb, input string tag);
        int n = 0, cyc = 0, stalls = 0, bubbles = 0, notbusy = 0, early_done = 0;
        bit prev_stall = 1'b0;
        rule  = r;
        start = 1'b1;
        wr    = 1'b0;
        step();
        start = 1'b0;
        check({tag, " seed_write"}, m_write, 1'b0);
        check({tag, " seed_busy"}, m_busy, 1'b1);
        step();
        while (n < 8 * nrows && cyc < 2000) begin
            wr = stall ? ($urandom_range(0, 1) == 1) : 1'b0;
            if (disturb && cyc == 5) begin
                start = 1'b1;
                rule  = ~r;
            end else begin
                start = 1'b0;
            end
            if (m_busy !== 1'b1) notbusy++;
            if (m_done !== 1'b0) early_done++;
            if (prev_stall) check({tag, " stall_write_held"}, m_write, 1'b1);
            if (m_write === 1'b1) begin
                check({tag, " addr"}, m_addr, n);
                check({tag, " data"}, m_data, rows[n] ? 16'h0FFF : 16'h0000);
                if (wr == 1'b0) n++;
                else stalls++;
                prev_stall = wr;
            end else begin
                bubbles++;
                prev_stall = 1'b0;
            end
            cyc++;
            step();
        end
        wr    = 1'b0;
        start = 1'b0;
        check({tag, " write_count"}, n, 8 * nrows);
        check({tag, " cycles"}, cyc, 8 * nrows + nrows - 1 + stalls);
        check({tag, " bubbles"}, bubbles, nrows - 1);
        check({tag, " busy_gaps"}, notbusy, 0);
        check({tag, " early_done"}, early_done, 0);
        check({tag, " done_pulse"}, m_done, 1'b1);
        check({tag, " done_write"}, m_write, 1'b0);
        check({tag, " done_busy"}, m_busy, 1'b1);
        step();
        check({tag, " done_clear"}, m_done, 1'b0);
        check({tag, " idle_busy"}, m_busy, 1'b0);
    endtask

    initial begin
        int nw, fg, fg_addr, last, aerr, derr, cyc;
        bit found;
        rst_n   = 1'b0;
        rule    = 8'h00;
        start   = 1'b0;
        wr      = 1'b0;
        sel     = 1'b0;
        b_start = 1'b0;
        #12;
        check("rst_write", s_write, 1'b0);
        check("rst_addr", s_addr, 0);
        check("rst_data", s_data, 16'h0000);
        check("rst_busy", s_busy, 1'b0);
        check("rst_done", s_done, 1'b0);
        check("rst_big_write", b_write, 1'b0);
        rst_n = 1'b1;
        step();

        // Full default-size frame, rule 0.
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        nw = 0; fg = 0; fg_addr = -1; last = -1; aerr = 0; derr = 0; cyc = 0;
        while (b_done !== 1'b1 && cyc < 80000) begin
            if (b_write === 1'b1) begin
                if (b_addr != 18'(nw)) aerr++;
                if (b_data === 16'h0FFF) begin
                    fg++;
                    fg_addr = int'(b_addr);
                end else if (b_data !== 16'h0000) begin
                    derr++;
                end
                last = int'(b_addr);
                nw++;
            end
            cyc++;
            step();
        end
        check("big_done", b_done, 1'b1);
        check("big_writes", nw, 76800);
        check("big_fg_count", fg, 1);
        check("big_fg_addr", fg_addr, 160);
        check("big_last_addr", last, 76799);
        check("big_addr_seq", aerr, 0);
        check("big_data_val", derr, 0);
        step();
        check("big_idle_busy", b_busy, 1'b0);

        frame(8'd90,  {8'hAA, 8'h44, 8'h28, 8'h10}, 4, 1'b0, 1'b0, "r90");
        frame(8'd30,  {8'hF6, 8'h4C, 8'h38, 8'h10}, 4, 1'b0, 1'b0, "r30");
        frame(8'd30,  {8'hF6, 8'h4C, 8'h38, 8'h10}, 4, 1'b1, 1'b0, "r30_stall");
        frame(8'd90,  {8'hAA, 8'h44, 8'h28, 8'h10}, 4, 1'b0, 1'b1, "r90_disturb");
        sel = 1'b1;
        frame(8'd255, {8'h00, 8'hFF, 8'hFF, 8'h10}, 3, 1'b0, 1'b0, "r255_tri");
        sel = 1'b0;

        // Reset in the middle of row 2, then restart with a different rule.
        rule  = 8'd90;
        start = 1'b1;
        step();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (s_write === 1'b1 && s_addr == 18'd19) found = 1'b1;
            else step();
        end
        check("rst_mid_reached", found, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_write", s_write, 1'b0);
        check("rst_mid_busy", s_busy, 1'b0);
        check("rst_mid_addr", s_addr, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("rst_after_idle", s_busy, 1'b0);
        frame(8'd255, {8'hFF, 8'hFF, 8'hFF, 8'h10}, 4, 1'b0, 1'b0, "r255_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
